// File: rtl/uni_regn_pkg.sv
// Shared definitions for the uni_regn universal register: MODE encoding
// and the width of the shift/rotate counter.
package uni_regn_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROTL = 3'b100,
    MODE_ROTR = 3'b101,
    MODE_INC  = 3'b110,
    MODE_DEC  = 3'b111
  } mode_e;

  // Bits needed to hold a count from 0 up to and including w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  // Modes that move data positionally and therefore advance the counter.
  function automatic logic is_shift(input mode_e m);
    return (m == MODE_SHL) || (m == MODE_SHR) ||
           (m == MODE_ROTL) || (m == MODE_ROTR);
  endfunction

endpackage

// File: rtl/uni_regn_satcnt.sv
// Saturating up-counter from 0 to MAX with synchronous clear (clear wins
// over inc) and asynchronous active-low reset. full is combinational.
module uni_regn_satcnt
  import uni_regn_pkg::*;
#(
  parameter int MAX = 8,
  parameter int CW  = cnt_width(MAX)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          full
);

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX);

  assign full = (cnt == CNT_MAX);

  // Count up on inc, stick at MAX, return to zero on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && !full) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uni_regn.sv
// uni_regn: universal register with hold / load / shift / rotate /
// increment / decrement, a saturating count of shifts since the last load,
// and a wrap flag for INC/DEC. WIDTH legal range is 2..32.
// Optional build macro UNI_REGN_SCLR_EN adds a synchronous clear input
// SCLR that overrides EN and MODE.
module uni_regn
  import uni_regn_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                          CLK,
  input  logic                          CLR_B,
`ifdef UNI_REGN_SCLR_EN
  input  logic                          SCLR,
`endif
  input  logic                          EN,
  input  logic [2:0]                    MODE,
  input  logic [WIDTH-1:0]              D,
  input  logic                          SI_R,
  input  logic                          SI_L,
  output logic [WIDTH-1:0]              Q,
  output logic                          SO_L,
  output logic                          SO_R,
  output logic [cnt_width(WIDTH)-1:0]   CNT,
  output logic                          FULL,
  output logic                          CO
);

  localparam int CW = cnt_width(WIDTH);

  mode_e mode;
  logic  sclr;
  logic  cnt_clear;
  logic  cnt_inc;

  assign mode = mode_e'(MODE);

`ifdef UNI_REGN_SCLR_EN
  assign sclr = SCLR;
`else
  assign sclr = 1'b0;
`endif

  // Serial outputs come straight from the register, never from inputs.
  assign SO_L = Q[WIDTH-1];
  assign SO_R = Q[0];

  // LOAD restarts the count; a synchronous clear restarts it too.
  assign cnt_clear = sclr || (EN && (mode == MODE_LOAD));
  assign cnt_inc   = EN && is_shift(mode);

  uni_regn_satcnt #(
    .MAX (WIDTH),
    .CW  (CW)
  ) u_satcnt (
    .clk   (CLK),
    .rst_n (CLR_B),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .cnt   (CNT),
    .full  (FULL)
  );

  // Data register and wrap flag: one operation per enabled clock edge.
  always_ff @(posedge CLK or negedge CLR_B) begin
    if (!CLR_B) begin
      Q  <= '0;
      CO <= 1'b0;
    end else if (sclr) begin
      Q  <= '0;
      CO <= 1'b0;
    end else if (EN) begin
      unique case (mode)
        MODE_HOLD: begin
          Q  <= Q;
          CO <= CO;
        end
        MODE_LOAD: begin
          Q  <= D;
          CO <= 1'b0;
        end
        MODE_SHL: begin
          Q  <= {Q[WIDTH-2:0], SI_R};
          CO <= 1'b0;
        end
        MODE_SHR: begin
          Q  <= {SI_L, Q[WIDTH-1:1]};
          CO <= 1'b0;
        end
        MODE_ROTL: begin
          Q  <= {Q[WIDTH-2:0], Q[WIDTH-1]};
          CO <= 1'b0;
        end
        MODE_ROTR: begin
          Q  <= {Q[0], Q[WIDTH-1:1]};
          CO <= 1'b0;
        end
        MODE_INC: begin
          Q  <= Q + WIDTH'(1);
          CO <= &Q;
        end
        MODE_DEC: begin
          Q  <= Q - WIDTH'(1);
          CO <= ~|Q;
        end
        default: begin
          Q  <= Q;
          CO <= CO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uni_regn.sv
// Bench for uni_regn at WIDTH=4: directed scenarios followed by random
// operations with occasional asynchronous clear pulses, checked against an
// arithmetic reference model.
module tb_uni_regn;

  localparam int W  = 4;
  localparam int M  = 1 << W;
  localparam int CW = $clog2(W + 1);

  logic          clk;
  logic          clr_b;
  logic          sclr;
  logic          en;
  logic [2:0]    mode;
  logic [W-1:0]  d;
  logic          si_r;
  logic          si_l;
  logic [W-1:0]  q;
  logic          so_l;
  logic          so_r;
  logic [CW-1:0] cnt;
  logic          full;
  logic          co;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int m_q;
  int m_cnt;
  int m_co;
  logic [W-1:0] exp_q[$];

  uni_regn #(.WIDTH(W)) dut (
    .CLK   (clk),
    .CLR_B (clr_b),
`ifdef UNI_REGN_SCLR_EN
    .SCLR  (sclr),
`endif
    .EN    (en),
    .MODE  (mode),
    .D     (d),
    .SI_R  (si_r),
    .SI_L  (si_l),
    .Q     (q),
    .SO_L  (so_l),
    .SO_R  (so_r),
    .CNT   (cnt),
    .FULL  (full),
    .CO    (co)
  );

  // clock: posedges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q = 0;
    m_cnt = 0;
    m_co = 0;
  endtask

  // Reference behaviour expressed as integer arithmetic on the value.
  task automatic model_step(input bit s_en, input int s_mode, input int s_d,
                            input int s_sil, input int s_sir, input bit s_sclr);
    if (s_sclr) begin
      model_clear();
    end else if (s_en) begin
      case (s_mode)
        0: ;
        1: begin m_q = s_d; m_cnt = 0; m_co = 0; end
        2: m_q = (m_q * 2 + s_sir) % M;
        3: m_q = m_q / 2 + s_sil * (M / 2);
        4: m_q = (m_q * 2) % M + m_q / (M / 2);
        5: m_q = m_q / 2 + (m_q % 2) * (M / 2);
        6: begin m_co = (m_q == M - 1); m_q = (m_q + 1) % M; end
        7: begin m_co = (m_q == 0); m_q = (m_q + M - 1) % M; end
        default: ;
      endcase
      if (s_mode >= 2 && s_mode <= 5) begin
        m_co = 0;
        if (m_cnt < W) m_cnt = m_cnt + 1;
      end
    end
    exp_q.push_back(W'(m_q));
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] e;
    e = exp_q.pop_front();
    check({tag, ".q"},    32'(q),    32'(e));
    check({tag, ".cnt"},  32'(cnt),  32'(m_cnt));
    check({tag, ".co"},   32'(co),   32'(m_co));
    check({tag, ".full"}, 32'(full), 32'(m_cnt == W));
    check({tag, ".so_l"}, 32'(so_l), 32'(m_q / (M / 2)));
    check({tag, ".so_r"}, 32'(so_r), 32'(m_q % 2));
  endtask

  // Drive one operation at the negedge, check #1 after the following posedge.
  task automatic op(input string tag, input bit o_en, input int o_mode, input int o_d,
                    input int o_sil, input int o_sir, input bit o_sclr);
    @(negedge clk);
    en   = o_en;
    mode = 3'(o_mode);
    d    = W'(o_d);
    si_l = 1'(o_sil);
    si_r = 1'(o_sir);
    sclr = o_sclr;
    model_step(o_en, o_mode, o_d, o_sil, o_sir, o_sclr);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Asynchronous clear pulse placed between clock edges (call right after op).
  task automatic clr_pulse(input string tag);
    #1 clr_b = 1'b0;
    #1;
    model_clear();
    exp_q.push_back(W'(0));
    check_all(tag);
    #1 clr_b = 1'b1;
  endtask

  initial begin
    clr_b = 1'b1;
    sclr  = 1'b0;
    en    = 1'b0;
    mode  = 3'd0;
    d     = '0;
    si_r  = 1'b0;
    si_l  = 1'b0;

    // clear pulse 20 ns after start, checked before the 25 ns edge
    #20 clr_b = 1'b0;
    #2;
    model_clear();
    exp_q.push_back(W'(0));
    check_all("rst");
    #1 clr_b = 1'b1;

    // load then hold with EN low while D toggles
    op("ld_e", 1, 1, 4'b1110, 0, 0, 0);
    op("hold1", 0, 1, 4'b1011, 1, 1, 0);
    op("hold2", 0, 2, 4'b0011, 1, 1, 0);
    op("hold3", 0, 6, 4'b0100, 1, 1, 0);

    // shift-left ones into zero until saturation
    op("ld_0", 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) op("shl", 1, 2, 0, 0, 1, 0);

    // wrap on INC / DEC
    op("ld_f", 1, 1, 4'b1111, 0, 0, 0);
    op("inc_wrap", 1, 6, 0, 0, 0, 0);
    op("dec_wrap", 1, 7, 0, 0, 0, 0);
    op("dec", 1, 7, 0, 0, 0, 0);
    op("hold_co", 1, 0, 0, 0, 0, 0);

    // rotate interrupted by asynchronous clear
    op("ld_9", 1, 1, 4'b1001, 0, 0, 0);
    op("rotr1", 1, 5, 0, 0, 0, 0);
    clr_pulse("mid_clr");
    op("rotr2", 1, 5, 0, 0, 0, 0);

    // remaining modes once each
    op("ld_6", 1, 1, 4'b0110, 0, 0, 0);
    op("shr", 1, 3, 0, 1, 0, 0);
    op("rotl", 1, 4, 0, 0, 0, 0);

`ifdef UNI_REGN_SCLR_EN
    op("sclr_ld", 1, 1, 4'b1010, 0, 0, 1);
    op("ld_5", 1, 1, 4'b0101, 0, 0, 0);
    op("sclr_en0", 0, 2, 0, 0, 0, 1);
`endif

    // random operations
    for (int i = 0; i < 400; i++) begin
      bit r_sclr;
      r_sclr = 1'b0;
`ifdef UNI_REGN_SCLR_EN
      r_sclr = ($urandom_range(0, 19) == 0);
`endif
      op("rnd", ($urandom_range(0, 9) != 0), $urandom_range(0, 7), $urandom_range(0, M - 1),
         $urandom_range(0, 1), $urandom_range(0, 1), r_sclr);
      if ($urandom_range(0, 39) == 0) clr_pulse("rnd_clr");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
